// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI mode-0 target (spi_slave_if).
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam logic [7:0]  IDLE_TX_DEF = 8'h00;

  function automatic int unsigned cnt_w(input int unsigned dw);
    return $clog2(dw) + 1;
  endfunction

endpackage

// File: rtl/spi_slave_if_sync_edge.sv
// Multi-stage synchroniser with rise/fall detection on the last two samples.
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              w_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign w_q    = r_sync[STAGES-1];
  assign o_rise =  w_q & ~r_prev;
  assign o_fall = ~w_q &  r_prev;

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 target on the system clock with one-entry tx buffer.
// Define SPI_SLAVE_LSB_FIRST_EN for LSB-first shifting (default MSB-first).
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int unsigned         DATA_W      = DATA_W_DEF,
  parameter int unsigned         SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0]   IDLE_TX     = IDLE_TX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_abort,
  output logic              tx_underrun
);

  localparam int unsigned CW = cnt_w(DATA_W);

  logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic w_mosi;

  state_t r_state, w_state_nxt;
  logic   w_start, w_end;

  logic [DATA_W-1:0] r_buf, r_tx_sh, r_rx_sh, r_rx_data;
  logic [DATA_W-1:0] w_rx_word, w_tx_shift;
  logic              r_buf_full, r_reload, r_rx_valid, r_abort, r_underrun;
  logic [CW-1:0]     r_cnt;
  logic              w_tx_bit, w_rise_act, w_fall_act, w_fill, w_consume, w_load, w_last;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .i_clk(clk), .i_rst_n(reset), .i_d(sclk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .i_clk(clk), .i_rst_n(reset), .i_d(cs_n), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  always_ff @(posedge clk) begin
    if (!reset) r_mosi_sync <= '0;
    else        r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
  end
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_end       = 1'b0;
    miso        = 1'b0;
    miso_oe     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = SHIFT;
          w_start     = 1'b1;
        end
      end
      SHIFT: begin
        miso    = w_tx_bit;
        miso_oe = 1'b1;
        if (w_cs_rise) begin
          w_state_nxt = IDLE;
          w_end       = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign w_rx_word  = {w_mosi, r_rx_sh[DATA_W-1:1]};
  assign w_tx_bit   = r_tx_sh[0];
  assign w_tx_shift = {1'b0, r_tx_sh[DATA_W-1:1]};
`else
  assign w_rx_word  = {r_rx_sh[DATA_W-2:0], w_mosi};
  assign w_tx_bit   = r_tx_sh[DATA_W-1];
  assign w_tx_shift = {r_tx_sh[DATA_W-2:0], 1'b0};
`endif

  // sclk edges are ignored in the cycle cs_n rises, and in IDLE (covers cs_n-fall collisions)
  assign w_rise_act = (r_state == SHIFT) && !w_cs_rise && w_sclk_rise;
  assign w_fall_act = (r_state == SHIFT) && !w_cs_rise && w_sclk_fall;
  assign w_fill     = w_start || (w_fall_act && r_reload);
  assign w_consume  = w_fill && r_buf_full;
  assign w_load     = tx_valid && !r_buf_full;
  assign w_last     = (r_cnt == CW'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_abort    <= 1'b0;
      r_underrun <= 1'b0;
      r_reload   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      r_abort    <= 1'b0;

      if (w_load) begin
        r_buf      <= tx_data;
        r_buf_full <= 1'b1;
      end else if (w_consume) begin
        r_buf_full <= 1'b0;
      end

      if (w_fill) begin
        r_tx_sh  <= r_buf_full ? r_buf : IDLE_TX;
        r_reload <= 1'b0;
        if (!r_buf_full) r_underrun <= 1'b1;
      end else if (w_fall_act) begin
        r_tx_sh <= w_tx_shift;
      end

      if (w_start) r_cnt <= '0;

      if (w_rise_act) begin
        r_rx_sh <= w_rx_word;
        if (w_last) begin
          r_cnt      <= '0;
          r_rx_data  <= w_rx_word;
          r_rx_valid <= 1'b1;
          r_reload   <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end

      if (w_end) begin
        r_cnt    <= '0;
        r_reload <= 1'b0;
        if (r_cnt != '0) r_abort <= 1'b1;
      end
    end
  end

  assign tx_ready    = !r_buf_full;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign frame_abort = r_abort;
  assign tx_underrun = r_underrun;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if acting as an SPI mode-0 master at clk/8.
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe, tx_ready, rx_valid, frame_abort, tx_underrun;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic [7:0] rx_data;

  int n_checks = 0;
  int n_errors = 0;

  int         rx_cnt = 0;
  int         ab_cnt = 0;
  logic [7:0] rx_last1 = 8'h00;
  logic [7:0] rx_last2 = 8'h00;

  spi_slave_if #(.DATA_W(8), .SYNC_STAGES(2), .IDLE_TX(8'h00)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_abort(frame_abort), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt   = rx_cnt + 1;
      rx_last2 = rx_last1;
      rx_last1 = rx_data;
    end
    if (frame_abort) ab_cnt = ab_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_tx(input logic [7:0] v);
    @(negedge clk);
    tx_data  = v;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    #40;
  endtask

  task automatic cs_high();
    #40;
    cs_n = 1'b1;
    mosi = 1'b0;
    #80;
  endtask

  // One master bit per 80 ns; miso sampled just before the rising sclk edge
  task automatic shift_bits(input logic [7:0] tx_b, input int n, output logic [7:0] got);
    int idx;
    got = 8'h00;
    for (int i = 0; i < n; i++) begin
`ifdef SPI_SLAVE_LSB_FIRST_EN
      idx = i;
`else
      idx = 7 - i;
`endif
      mosi = tx_b[idx];
      #30;
      got[idx] = miso;
      #10 sclk = 1'b1;
      #40 sclk = 1'b0;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_miso"},     miso,        1'b0);
    chk({tag, "_miso_oe"},  miso_oe,     1'b0);
    chk({tag, "_tx_ready"}, tx_ready,    1'b1);
    chk({tag, "_rx_data"},  rx_data,     8'h00);
    chk({tag, "_rx_valid"}, rx_valid,    1'b0);
    chk({tag, "_abort"},    frame_abort, 1'b0);
    chk({tag, "_underrun"}, tx_underrun, 1'b0);
  endtask

  logic [7:0] got;
  int         base_rx, base_ab;

  initial begin
    repeat (4) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Underrun: empty buffer at frame start
    base_rx = rx_cnt;
    cs_low();
    chk("udr_set", tx_underrun, 1'b1);
    chk("udr_oe", miso_oe, 1'b1);
    shift_bits(8'h55, 8, got);
    cs_high();
    chk("udr_miso", got, 8'h00);
    chk("udr_rx", rx_data, 8'h55);
    chk("udr_rxcnt", rx_cnt - base_rx, 1);
    chk("udr_sticky", tx_underrun, 1'b1);
    chk("udr_desel_miso", miso, 1'b0);
    chk("udr_desel_oe", miso_oe, 1'b0);

    // Single frame
    load_tx(8'hA5);
    chk("sf_ready_lo", tx_ready, 1'b0);
    base_rx = rx_cnt;
    cs_low();
    chk("sf_ready_hi", tx_ready, 1'b1);
    chk("sf_first_bit", miso, 1'b1);
    shift_bits(8'h3C, 8, got);
    cs_high();
    chk("sf_miso", got, 8'hA5);
    chk("sf_rx", rx_data, 8'h3C);
    chk("sf_rxcnt", rx_cnt - base_rx, 1);

    // Back-to-back frames under one cs_n
    load_tx(8'h11);
    base_rx = rx_cnt;
    cs_low();
    load_tx(8'h22);
    shift_bits(8'hF0, 8, got);
    chk("b2b_miso0", got, 8'h11);
    shift_bits(8'h0F, 8, got);
    chk("b2b_miso1", got, 8'h22);
    cs_high();
    chk("b2b_rxcnt", rx_cnt - base_rx, 2);
    chk("b2b_rx0", rx_last2, 8'hF0);
    chk("b2b_rx1", rx_data, 8'h0F);

    // Abort after 5 bits, then a full frame
    base_rx = rx_cnt;
    base_ab = ab_cnt;
    cs_low();
    shift_bits(8'hFF, 5, got);
    cs_high();
    chk("ab_pulse", ab_cnt - base_ab, 1);
    chk("ab_no_rx", rx_cnt - base_rx, 0);
    chk("ab_rx_hold", rx_data, 8'h0F);
    cs_low();
    shift_bits(8'h81, 8, got);
    cs_high();
    chk("ab_next_rx", rx_data, 8'h81);
    chk("ab_next_rxcnt", rx_cnt - base_rx, 1);
    chk("ab_no_extra", ab_cnt - base_ab, 1);

    // Reset mid-frame after 3 bits
    cs_low();
    shift_bits(8'hAA, 3, got);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("mrst");
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    load_tx(8'h5A);
    base_rx = rx_cnt;
    cs_low();
    shift_bits(8'hC3, 8, got);
    cs_high();
    chk("mrst_miso", got, 8'h5A);
    chk("mrst_rx", rx_data, 8'hC3);
    chk("mrst_rxcnt", rx_cnt - base_rx, 1);

`ifdef SPI_SLAVE_LSB_FIRST_EN
    load_tx(8'h01);
    cs_low();
    chk("lsb_first_bit", miso, 1'b1);
    shift_bits(8'h80, 8, got);
    cs_high();
    chk("lsb_miso", got, 8'h01);
    chk("lsb_rx", rx_data, 8'h80);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
